census_cost_10: RTL and testbench

CENSUS_COST_10 -- requirements
Module: census_cost_10

---
 rtl/census_cost_10.sv | 58 +++++
 tb/tb_census_cost_10.sv | 125 ++++++++++++
 2 files changed

// File: rtl/census_cost_10.sv
// census_cost_10: census matching costs for disparities 0..9, two-stage pipeline
module census_cost_10 #(
  parameter int CENSUS_BITS = 24,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   line_start,
  input  logic [CENSUS_BITS-1:0] left_census,
  input  logic [CENSUS_BITS-1:0] right_census,
  output logic                   out_valid,
  output logic [10*WIDTH-1:0]    costs
);
  logic [CENSUS_BITS-1:0] r_hist [10];
  logic [CENSUS_BITS-1:0] r_x [10];
  logic [CENSUS_BITS-1:0] w_shift [10];
  logic [3:0]             r_cnt, w_cnt;
  logic [9:0]             r_mask, w_mask;
  logic                   r_v1;
  logic [10*WIDTH-1:0]    w_costs;

  function automatic logic [WIDTH-1:0] pop(input logic [CENSUS_BITS-1:0] x);
    pop = '0;
    for (int i = 0; i < CENSUS_BITS; i++) pop = pop + WIDTH'(x[i]);
  endfunction

  // history is the post-shift view: slot 0 is the current right descriptor
  always_comb begin
    w_cnt = line_start ? 4'd1 : (r_cnt == 4'd10 ? 4'd10 : r_cnt + 4'd1);
    w_shift[0] = right_census;
    for (int d = 1; d < 10; d++) w_shift[d] = r_hist[d-1];
    for (int d = 0; d < 10; d++) w_mask[d] = w_cnt > 4'(d);
    for (int d = 0; d < 10; d++) w_costs[d*WIDTH +: WIDTH] = r_mask[d] ? pop(r_x[d]) : '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist    <= '{default: '0};
      r_x       <= '{default: '0};
      r_cnt     <= '0;
      r_mask    <= '0;
      r_v1      <= 1'b0;
      out_valid <= 1'b0;
      costs     <= '0;
    end else begin
      r_v1      <= in_valid;
      out_valid <= r_v1;
      if (in_valid) begin
        r_hist <= w_shift;
        r_cnt  <= w_cnt;
        r_mask <= w_mask;
        for (int d = 0; d < 10; d++) r_x[d] <= left_census ^ w_shift[d];
      end
      if (r_v1) costs <= w_costs;
    end
  end
endmodule

// File: tb/tb_census_cost_10.sv
// tb_census_cost_10: directed and random stimulus against a queue-based reference
module tb_census_cost_10;
  logic         clk = 1'b0;
  logic         rst, in_valid, line_start, out_valid;
  logic [23:0]  left_census, right_census;
  logic [319:0] costs;

  census_cost_10 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .line_start(line_start),
    .left_census(left_census), .right_census(right_census),
    .out_valid(out_valid), .costs(costs)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [23:0]  hist [$];
  logic         d1v = 1'b0, e_v = 1'b0;
  logic [319:0] d1c = '0, e_c = '0;
  logic [319:0] all_hi;
  logic [23:0]  rq [$];

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [319:0] costs_of(input logic [23:0] l);
    logic [319:0] c;
    for (int d = 0; d < 10; d++)
      c[d*32 +: 32] = d < hist.size() ? 32'($countones(l ^ hist[d])) : 32'hFFFFFFFF;
    return c;
  endfunction

  function automatic int argmin(input logic [319:0] c);
    int a = 0;
    for (int d = 1; d < 10; d++) if (c[d*32 +: 32] < c[a*32 +: 32]) a = d;
    return a;
  endfunction

  task automatic cyc(input logic v, input logic ls, input logic [23:0] l, input logic [23:0] r,
                     input logic rs);
    rst = rs; in_valid = v; line_start = ls; left_census = l; right_census = r;
    @(posedge clk);
    if (rs) begin
      e_v = 1'b0; e_c = '0; d1v = 1'b0; hist.delete();
    end else begin
      e_v = d1v;
      if (d1v) e_c = d1c;
      d1v = v;
      if (v) begin
        if (ls) hist.delete();
        hist.push_front(r);
        if (hist.size() > 10) void'(hist.pop_back());
        d1c = costs_of(l);
      end
    end
    #1;
    chk("out_valid", {319'b0, out_valid}, {319'b0, e_v});
    chk("costs", costs, e_c);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, $urandom, $urandom, 1'b0);
  endtask

  initial begin
    all_hi = '1;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("reset_costs", costs, '0);
    for (int k = 1; k <= 12; k++) cyc(1, k == 1, 24'h5A5A5A, 24'h5A5A5A, 0);
    idle(); idle();
    chk("ident_last", costs, '0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 24'h000000, 24'h000000, 0);
    cyc(1, 0, 24'h000000, 24'hFFFFFF, 0);
    cyc(1, 0, 24'h000000, 24'h00000F, 0);
    idle(); idle();
    chk("known", costs, {{7{32'hFFFFFFFF}}, 32'd0, 32'd24, 32'd4});
    for (int k = 0; k < 15; k++) cyc(1, k == 0, $urandom, $urandom, 0);
    cyc(1, 1, $urandom, $urandom, 0);
    idle(); idle();
    chk("restart_mask", {32'b0, costs[319:32]}, {32'b0, all_hi[319:32]});
    for (int k = 0; k < 4; k++) cyc(1, 0, $urandom, $urandom, 0);
    cyc(1, 0, $urandom, $urandom, 0);
    idle(); idle();
    cyc(1, 0, $urandom, $urandom, 0);
    idle(); idle();
    cyc(1, 0, $urandom, $urandom, 0);
    cyc(1, 0, $urandom, $urandom, 0);
    cyc(0, 0, 0, 0, 1);
    idle();
    chk("rst_drop_costs", costs, '0);
    idle();
    chk("rst_drop_valid", {319'b0, out_valid}, '0);
    cyc(1, 0, $urandom, $urandom, 0);
    idle(); idle();
    chk("post_rst_ls", {32'b0, costs[319:32]}, {32'b0, all_hi[319:32]});
    begin
      int k_out = 0;
      rq.delete();
      for (int k = 1; k <= 16; k++) begin
        logic [23:0] r, l;
        r = {k[7:0], 16'($urandom)};
        rq.push_back(r);
        l = k >= 4 ? rq[k-4] : 24'($urandom);
        cyc(1, k == 1, l, r, 0);
        if (out_valid) begin
          k_out++;
          if (k_out >= 4) chk("argmin", 320'(argmin(costs)), 320'd3);
        end
      end
    end
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom, $urandom,
          $urandom_range(0, 49) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
